// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with registered read port, runtime almost-full/empty
// thresholds, hysteretic upstream pause and a sticky overflow/underflow flag.
module fifo_param #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 pop,
    input  logic [ADDR_SIZE:0]   af_thr,
    input  logic [ADDR_SIZE:0]   ae_thr,
    input  logic                 err_clr,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic [ADDR_SIZE:0]   data_count,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 fifo_pause,
    output logic                 fifo_error
);

    localparam int CNT_W = ADDR_SIZE + 1;
    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    localparam logic [0:0] PAUSE_OFF = 1'b0;
    localparam logic [0:0] PAUSE_ON  = 1'b1;

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_valid;
    logic                 r_error;
    logic [0:0]           r_pause_st;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop_ok;
    logic                 w_push_ok;
    logic                 w_overflow;
    logic                 w_underflow;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [0:0]           w_pause_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    assign w_pop_ok  = pop & ~w_empty;
    assign w_push_ok = push & (~w_full | w_pop_ok);

    assign w_overflow  = push & w_full & ~pop;
    assign w_underflow = pop & w_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + ONE_C;
            2'b01:   w_count_nxt = r_count - ONE_C;
            default: w_count_nxt = r_count;
        endcase
    end

    // Assert wins over release so misconfigured thresholds fail safe (paused).
    always_comb begin
        w_pause_nxt = r_pause_st;
        if (r_count >= af_thr) begin
            w_pause_nxt = PAUSE_ON;
        end else if ((r_pause_st == PAUSE_ON) && (r_count <= ae_thr)) begin
            w_pause_nxt = PAUSE_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    // A fresh error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_overflow || w_underflow) begin
            r_error <= 1'b1;
        end else if (err_clr) begin
            r_error <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pause_st <= PAUSE_OFF;
        end else begin
            r_pause_st <= w_pause_nxt;
        end
    end

    assign data_out     = r_data_out;
    assign valid_out    = r_valid;
    assign data_count   = r_count;
    assign fifo_empty   = w_empty;
    assign fifo_full    = w_full;
    assign almost_full  = (r_count >= af_thr);
    assign almost_empty = (r_count <= ae_thr) && !w_empty;
    assign fifo_pause   = (r_pause_st == PAUSE_ON);
    assign fifo_error   = r_error;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed scenarios plus randomized traffic against a queue-based
// reference model; popped words are checked by a scoreboard monitor on valid_out.
module tb_fifo_param;

    localparam int DW    = 6;
    localparam int AW    = 2;
    localparam int CW    = AW + 1;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pop = 1'b0;
    logic [CW-1:0] af_thr = 3'd4;
    logic [CW-1:0] ae_thr = 3'd0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [CW-1:0] data_count;
    logic          fifo_empty, fifo_full, almost_full, almost_empty, fifo_pause, fifo_error;

    fifo_param #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .af_thr(af_thr), .ae_thr(ae_thr), .err_clr(err_clr),
        .data_out(data_out), .valid_out(valid_out), .data_count(data_count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_full(almost_full),
        .almost_empty(almost_empty), .fifo_pause(fifo_pause), .fifo_error(fifo_error)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic          m_err = 1'b0;
    logic          m_pause = 1'b0;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_dout = '0;

    int n_vec = 0;
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic p, input logic [DW-1:0] d, input logic q,
                              input logic clr, input logic rst);
        int  cnt;
        bit  pop_ok, push_ok, bad;
        logic [DW-1:0] w;
        if (rst) begin
            mq.delete();
            m_err = 0; m_pause = 0; m_valid = 0; m_dout = '0;
            return;
        end
        cnt = mq.size();
        if (cnt >= int'(af_thr))      m_pause = 1;
        else if (cnt <= int'(ae_thr)) m_pause = 0;
        pop_ok  = q && (cnt > 0);
        push_ok = p && ((cnt < DEPTH) || pop_ok);
        bad     = (p && cnt == DEPTH && !q) || (q && cnt == 0);
        m_valid = pop_ok;
        if (pop_ok) begin
            w = mq.pop_front();
            exp_q.push_back(w);
            m_dout = w;
        end
        if (push_ok) mq.push_back(d);
        if (bad)      m_err = 1;
        else if (clr) m_err = 0;
    endtask

    task automatic step(input logic p, input logic [DW-1:0] d, input logic q,
                        input logic clr, input logic rst);
        int cnt;
        push = p; data_in = d; pop = q; err_clr = clr; reset = rst;
        @(posedge clk);
        model_edge(p, d, q, clr, rst);
        @(negedge clk);
        n_vec++;
        cnt = mq.size();
        chk("count", int'(data_count), cnt);
        chk("empty", int'(fifo_empty), int'(cnt == 0));
        chk("full", int'(fifo_full), int'(cnt == DEPTH));
        chk("almost_full", int'(almost_full), int'(cnt >= int'(af_thr)));
        chk("almost_empty", int'(almost_empty), int'(cnt <= int'(ae_thr) && cnt != 0));
        chk("pause", int'(fifo_pause), int'(m_pause));
        chk("error", int'(fifo_error), int'(m_err));
        chk("valid", int'(valid_out), int'(m_valid));
        chk("dout_hold", int'(data_out), int'(m_dout));
    endtask

    // Scoreboard monitor: every valid word must match the oldest expected pop.
    always @(negedge clk) begin
        logic [DW-1:0] w;
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", 1, 0);
            end else begin
                w = exp_q.pop_front();
                chk("sb_data", int'(data_out), int'(w));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pp, qp;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_dout", int'(data_out), 0);
        chk("rst_empty", int'(fifo_empty), 1);

        // Fill and drain
        for (int i = 1; i <= 4; i++) step(1, DW'(i), 0, 0, 0);
        chk("fill_count", int'(data_count), 4);
        chk("fill_full", int'(fifo_full), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        chk("drain_empty", int'(fifo_empty), 1);
        chk("drain_err", int'(fifo_error), 0);

        // Overflow, clear, underflow
        for (int i = 0; i < 4; i++) step(1, DW'(8'h10 + i), 0, 0, 0);
        step(1, 6'h3F, 0, 0, 0);
        chk("ovf_err", int'(fifo_error), 1);
        step(0, 0, 0, 1, 0);
        chk("clr_err", int'(fifo_error), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("udf_err", int'(fifo_error), 1);
        chk("udf_valid", int'(valid_out), 0);
        step(1, 6'h05, 1, 1, 0);
        step(0, 0, 1, 1, 0);

        // Simultaneous push/pop at full and at empty
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, DW'(8'h20 + i), 0, 0, 0);
        step(1, 6'h2A, 1, 0, 0);
        chk("sim_full_cnt", int'(data_count), 4);
        chk("sim_full_err", int'(fifo_error), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        step(1, 6'h15, 1, 0, 0);
        chk("sim_empty_cnt", int'(data_count), 1);
        chk("sim_empty_err", int'(fifo_error), 1);
        step(0, 0, 1, 1, 0);

        // Wrap-around with sequential data
        for (int i = 0; i < 10; i++) begin
            step(1, DW'(i + 1), (i != 0), 0, 0);
            chk("wrap_cnt_le2", int'(data_count <= 2), 1);
        end
        step(0, 0, 1, 0, 0);

        // Pause hysteresis
        af_thr = 3'd3; ae_thr = 3'd1;
        for (int i = 0; i < 3; i++) step(1, DW'(8'h30 + i), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pause_on", int'(fifo_pause), 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pause_hold", int'(fifo_pause), 1);
        step(0, 0, 1, 0, 0);
        chk("ae_at1", int'(almost_empty), 1);
        step(0, 0, 0, 0, 0);
        chk("pause_off", int'(fifo_pause), 0);
        step(0, 0, 1, 0, 0);
        chk("ae_at0", int'(almost_empty), 0);

        // Reset mid-operation
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, DW'(8'h38 + i), 0, 0, 0);
        step(1, 6'h11, 0, 0, 1);
        chk("mid_rst_cnt", int'(data_count), 0);
        chk("mid_rst_err", int'(fifo_error), 0);
        step(0, 0, 1, 0, 0);
        chk("post_rst_err", int'(fifo_error), 1);
        chk("post_rst_valid", int'(valid_out), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                af_thr = CW'($urandom_range(1, 5));
                ae_thr = CW'($urandom_range(0, 4));
            end
            pp = ((i / 100) % 2 == 0) ? 70 : 35;
            qp = 100 - pp;
            step($urandom_range(0, 99) < pp, DW'($urandom_range(0, 63)),
                 $urandom_range(0, 99) < qp, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 149) == 0);
        end

        step(0, 0, 0, 0, 0);
        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised single-clock FIFO, the successor to the fixed 6-bit/4-entry d-channel FIFOs in the arquitectura datapath. It adds generic width and depth, runtime almost-full/almost-empty thresholds, and a registered read port with a valid strobe. A hysteretic pause output drives upstream flow control, and a sticky error flag has an explicit clear. Each instance buffers one channel between the demux/arbiter stages and drives the upstream pause for that channel.

## Interface
Parameters:
- DATA_SIZE, 6, data word width in bits
- ADDR_SIZE, 2, pointer width; depth DEPTH = 2**ADDR_SIZE
- CNT_W, ADDR_SIZE+1, derived (localparam), width of count and thresholds

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- push  in  1  write request
- data_in  in  DATA_SIZE  write data
- pop  in  1  read request
- af_thr  in  CNT_W  almost-full threshold, sampled every cycle
- ae_thr  in  CNT_W  almost-empty threshold, sampled every cycle
- err_clr  in  1  clears fifo_error
- data_out  out  DATA_SIZE  registered read data
- valid_out  out  1  data_out holds a newly popped word this cycle
- data_count  out  CNT_W  number of stored words, 0..DEPTH
- fifo_empty  out  1  data_count == 0
- fifo_full  out  1  data_count == DEPTH
- almost_full  out  1  data_count >= af_thr
- almost_empty  out  1  data_count <= ae_thr and data_count != 0
- fifo_pause  out  1  registered flow-control request to upstream
- fifo_error  out  1  sticky overflow/underflow flag

## Operation
- Storage: DEPTH x DATA_SIZE register array. wr_ptr and rd_ptr are ADDR_SIZE wide and wrap modulo DEPTH with no special case.
- push_ok = push & (!fifo_full | pop_ok); pop_ok = pop & !fifo_empty.
- push_ok: mem[wr_ptr] <= data_in, wr_ptr++.
- pop_ok: data_out <= mem[rd_ptr], rd_ptr++, valid_out <= 1. Otherwise valid_out <= 0 and data_out holds its last value.
- Count update: push_ok & !pop_ok → +1; pop_ok & !push_ok → −1; both or neither → unchanged.
- Push and pop together while full: both accepted, count stays DEPTH, no error.
- Push and pop together while empty: push accepted, pop rejected, error set, count becomes 1.
- Overflow (push & fifo_full & !pop): data dropped, fifo_error <= 1.
- Underflow (pop & fifo_empty): no state change except fifo_error <= 1, valid_out <= 0.
- fifo_error is sticky. err_clr clears it next cycle. A new error in the same cycle as err_clr wins and keeps the flag at 1.
- Pause FSM, two states:
  - PAUSE_OFF → PAUSE_ON when data_count >= af_thr.
  - PAUSE_ON → PAUSE_OFF when data_count <= ae_thr.
  - If both conditions hold (misconfigured thresholds), the next state is PAUSE_ON.
  - fifo_pause = (state == PAUSE_ON).
- Flags are combinational from the registered data_count and the current thresholds.

## Timing
- Reset (synchronous, has priority over all other inputs):
  - Registered state after the reset edge: pointers 0, data_count 0, data_out 0, valid_out 0, fifo_error 0, pause state PAUSE_OFF.
  - Flags after the reset edge: fifo_empty 1; fifo_full, almost_full, almost_empty 0 (almost_full assumes af_thr > 0).
- A reset asserted mid-operation discards all contents on that edge. Pushes and pops in the same cycle as reset are ignored.
- Write latency: a word pushed at edge n is poppable at edge n+1. data_count and flags reflect it after edge n.
- Read latency: a pop accepted at edge n presents data_out with valid_out=1 after edge n, for exactly one cycle per pop. Back-to-back pops give back-to-back valid cycles.
- fifo_pause lags data_count by one cycle: the state after edge n+1 is decided from data_count after edge n.
- fifo_error rises in the cycle after the offending request.

## Test plan
- Fill/drain (DATA_SIZE=6, ADDR_SIZE=2): reset, push 0x01,0x02,0x03,0x04 → count 4, fifo_full 1; pop 4 times → data_out 0x01..0x04 with valid_out 1 each cycle, ending with fifo_empty 1 and fifo_error 0.
- Overflow/underflow: when full, push 0x3F without pop → count stays 4, fifo_error 1, and later pops never return 0x3F. Pulse err_clr → error 0. Pop when empty → error 1, valid_out 0.
- Simultaneous: when full, push 0x2A and pop together → pop returns the oldest word, count stays 4, no error. Continue draining → 0x2A is the last word out. When empty, push and pop together → count 1, error 1.
- Wrap-around: run 10 interleaved push/pop pairs with a sequential pattern across the pointer wrap → output order is preserved and count never exceeds 2.
- Pause hysteresis: af_thr=3, ae_thr=1. Push to 3 → fifo_pause 1 one cycle later. Pop to 2 → pause stays 1. Pop to 1 → pause 0 one cycle later. almost_empty is 1 at count 1 and 0 at count 0.
- Reset mid-operation: with 3 words stored and fifo_error 1, assert reset together with push → all outputs take their reset values, and a following pop sets the error and returns no data.
